// File: rtl/can_wb_master_arb.sv
// Round-robin arbiter and single-access Wishbone master that shares the CAN
// controller's register port among NREQ requesters, with a per-access ack timeout.
module can_wb_master_arb #(
    parameter int NREQ    = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*AW-1:0] adr_i,
    input  logic [NREQ*DW-1:0] dat_i,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    err_o,
    output logic [DW-1:0]      rdat_o,
    output logic               busy_o,
    output logic [2:0]         gnt_id_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [AW-1:0]      wb_adr_o,
    output logic [DW-1:0]      wb_dat_o,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic               wb_ack_i
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    GNT_LAST = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic            busy_q, busy_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;

    logic [7:0]      req_pad_s;
    logic [7:0]      we_pad_s;
    logic            pick_valid_s;
    logic [2:0]      pick_idx_s;
    logic [NREQ-1:0] gnt_onehot_s;

    // Zero-padded copies let a 3-bit index select any requester for any NREQ.
    always_comb begin
        req_pad_s = 8'h00;
        we_pad_s  = 8'h00;
        req_pad_s[NREQ-1:0] = req_i;
        we_pad_s[NREQ-1:0]  = we_i;
    end

    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            logic [3:0] idx;
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end else begin
                idx = idx;
            end
            if (!pick_valid_s && req_pad_s[idx[2:0]]) begin
                pick_valid_s = 1'b1;
                pick_idx_s   = idx[2:0];
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    assign gnt_onehot_s = NREQ'(1'b1) << gnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_BUS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wb_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion pulses are computed on the BUS exit edge so they land in RESP.
    always_comb begin
        ptr_d  = ptr_q;
        gnt_d  = gnt_q;
        cnt_d  = cnt_q;
        done_d = '0;
        err_d  = '0;
        rdat_d = rdat_q;
        busy_d = busy_q;
        cyc_d  = cyc_q;
        we_d   = we_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_d  = pick_idx_s;
                    we_d   = we_pad_s[pick_idx_s];
                    adr_d  = adr_i[int'(pick_idx_s)*AW +: AW];
                    dat_d  = dat_i[int'(pick_idx_s)*DW +: DW];
                    cyc_d  = 1'b1;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rdat_d = wb_dat_i;
                    end else begin
                        rdat_d = rdat_q;
                    end
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    done_d = gnt_onehot_s;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    done_d = gnt_onehot_s;
                    err_d  = gnt_onehot_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                busy_d = 1'b0;
                if (gnt_q >= GNT_LAST) begin
                    ptr_d = 3'd0;
                end else begin
                    ptr_d = gnt_q + 3'd1;
                end
            end
            default: begin
                busy_d = 1'b0;
                cyc_d  = 1'b0;
                we_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q  <= 3'd0;
            gnt_q  <= 3'd0;
            cnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            rdat_q <= '0;
            busy_q <= 1'b0;
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
            busy_q <= busy_d;
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
        end
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign rdat_o   = rdat_q;
    assign busy_o   = busy_q;
    assign gnt_id_o = gnt_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule
